// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU datapath slice.
//   - fetchState_t : encoding of the instruction fetch FSM (IDLE/REQ/WAIT/HOLD)
//   - RESET_PC     : default PC loaded when reset is asserted
//   - NOP_INSTR    : word presented to decode when no real instruction is held
//   - OPC_*        : primary opcode field values, shared with the Controller
//   - alignWord    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetchState_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // Instruction addresses are always word aligned, so any byte offset
    // supplied with a redirect is simply masked away.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// Pipeline register between fetch and decode.
//   Clk, Rst       : clock (rising edge) and asynchronous active-low reset
//   Load           : capture LoadWord / LoadPCPlus4 and mark the entry valid
//   Flush          : squash the entry (highest priority)
//   Stall          : decode cannot accept, hold the current entry
//   LoadWord       : instruction word to capture
//   LoadPCPlus4    : address of that instruction plus four
//   Instruction    : held instruction word (NOP_WORD when empty)
//   PCPlus4        : held address + 4
//   InstrValid     : entry holds a real instruction
// ---------------------------------------------------------------------------
module if_id_register #(
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic        Flush,
    input  logic        Stall,
    input  logic [31:0] LoadWord,
    input  logic [31:0] LoadPCPlus4,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

    // Priority is flush, then load, then hold-on-stall, then bubble.
    // A load is allowed to win over Stall because the fetch side only
    // asserts Load under stall when the register is empty, so nothing
    // the decode stage is looking at gets overwritten. PCPlus4 is left
    // alone on flush and bubble since it is meaningless without InstrValid.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Instruction <= NOP_WORD;
            PCPlus4     <= 32'h0000_0000;
            InstrValid  <= 1'b0;
        end else if (Flush) begin
            Instruction <= NOP_WORD;
            InstrValid  <= 1'b0;
        end else if (Load) begin
            Instruction <= LoadWord;
            PCPlus4     <= LoadPCPlus4;
            InstrValid  <= 1'b1;
        end else if (!Stall) begin
            Instruction <= NOP_WORD;
            InstrValid  <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: owns the PC, issues one outstanding request at a time to
// instruction memory and hands fetched words to decode through the IF/ID
// register.
//   Clk, Rst        : clock (rising edge), asynchronous active-low reset
//   Stall           : decode cannot accept, IF/ID must hold
//   PCSrc           : one-cycle taken-branch redirect from the Controller
//   BranchTarget    : redirect address (byte offset ignored)
//   IMemReq/IMemAddr: request and word-aligned address to instruction memory
//   IMemRdy         : memory accepts the request this cycle
//   IMemRespValid   : IMemRData carries the response this cycle
//   IMemRData       : fetched instruction word
//   Instruction     : IF/ID instruction word to decode
//   PCPlus4         : IF/ID address of that instruction + 4
//   InstrValid      : IF/ID holds a real instruction
//   PC              : current fetch PC (debug visibility)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic [31:0] PC
);

    cpu_pkg::fetchState_t state;
    cpu_pkg::fetchState_t stateNext;

    logic [31:0] pcReg;
    logic [31:0] pcNext;
    logic [31:0] inflightPc;
    logic [31:0] inflightNext;
    logic [31:0] holdBuf;
    logic [31:0] holdNext;
    logic        drop;
    logic        dropNext;

    logic        ifIdLoad;
    logic [31:0] ifIdWord;
    logic        canLoad;
    logic [31:0] redirectPc;
    logic [31:0] inflightPlus4;

    // IF/ID can take a new word if decode is consuming this cycle or the
    // register is empty anyway.
    assign canLoad       = !Stall || !InstrValid;
    assign redirectPc    = cpu_pkg::alignWord(BranchTarget);
    assign inflightPlus4 = inflightPc + 32'd4;

    // The request is a pure function of state and PC. While a request sits
    // unaccepted in REQ, a redirect moves the PC and the address follows it
    // on the next cycle, which the handshake permits.
    assign IMemReq  = (state == cpu_pkg::REQ);
    assign IMemAddr = pcReg;
    assign PC       = pcReg;

    // Next-state logic for the fetch FSM. The Drop flag marks an accepted
    // request whose response belongs to the wrong path and must be thrown
    // away when it finally arrives; it is how a redirect cancels a request
    // that memory has already taken. A redirect overrides any load in the
    // same cycle and always wins the PC update.
    always_comb begin
        stateNext    = state;
        pcNext       = pcReg;
        inflightNext = inflightPc;
        holdNext     = holdBuf;
        dropNext     = drop;
        ifIdLoad     = 1'b0;
        ifIdWord     = IMemRData;

        case (state)
            cpu_pkg::IDLE: begin
                stateNext = cpu_pkg::REQ;
            end
            cpu_pkg::REQ: begin
                if (IMemRdy) begin
                    inflightNext = pcReg;
                    stateNext    = cpu_pkg::WAIT;
                    if (PCSrc) begin
                        dropNext = 1'b1;
                    end
                end
            end
            cpu_pkg::WAIT: begin
                if (IMemRespValid) begin
                    stateNext = cpu_pkg::REQ;
                    dropNext  = 1'b0;
                    if (!drop && !PCSrc) begin
                        if (canLoad) begin
                            ifIdLoad = 1'b1;
                        end else begin
                            holdNext  = IMemRData;
                            stateNext = cpu_pkg::HOLD;
                        end
                    end
                end else if (PCSrc) begin
                    dropNext = 1'b1;
                end
            end
            cpu_pkg::HOLD: begin
                if (PCSrc) begin
                    stateNext = cpu_pkg::REQ;
                end else if (!Stall) begin
                    ifIdLoad  = 1'b1;
                    ifIdWord  = holdBuf;
                    stateNext = cpu_pkg::REQ;
                end
            end
            default: begin
                stateNext = cpu_pkg::IDLE;
            end
        endcase

        if (ifIdLoad) begin
            pcNext = inflightPlus4;
        end
        if (PCSrc) begin
            pcNext = redirectPc;
        end
    end

    // State, PC, in-flight address, hold buffer and Drop flag. Reset
    // abandons any outstanding request simply by forgetting it: the FSM
    // restarts in IDLE and stray responses outside WAIT are never looked at.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= cpu_pkg::IDLE;
            pcReg      <= RESET_PC;
            inflightPc <= RESET_PC;
            holdBuf    <= 32'h0000_0000;
            drop       <= 1'b0;
        end else begin
            state      <= stateNext;
            pcReg      <= pcNext;
            inflightPc <= inflightNext;
            holdBuf    <= holdNext;
            drop       <= dropNext;
        end
    end

    // The IF/ID register; PCSrc doubles as its flush so a redirect always
    // leaves a bubble behind it.
    if_id_register #(
        .NOP_WORD (NOP_INSTR)
    ) ifIdReg (
        .Clk         (Clk),
        .Rst         (Rst),
        .Load        (ifIdLoad),
        .Flush       (PCSrc),
        .Stall       (Stall),
        .LoadWord    (ifIdWord),
        .LoadPCPlus4 (inflightPlus4),
        .Instruction (Instruction),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. A table of per-cycle records
// holds the inputs for one cycle and the outputs expected after that clock
// edge; a hand-written sequence afterwards covers reset during a request.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRdy;
    logic        IMemRespValid;
    logic [31:0] IMemRData;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic [31:0] PC;

    int checks;
    int errors;

    typedef struct {
        logic        stall;
        logic        pcSrc;
        logic [31:0] target;
        logic        rdy;
        logic        respValid;
        logic [31:0] rData;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPcPlus4;
        logic        expValid;
        logic [31:0] expPc;
    } vector_t;

    vector_t vectors[$];

    instruction_fetch_unit dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Stall         (Stall),
        .PCSrc         (PCSrc),
        .BranchTarget  (BranchTarget),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemRdy       (IMemRdy),
        .IMemRespValid (IMemRespValid),
        .IMemRData     (IMemRData),
        .Instruction   (Instruction),
        .PCPlus4       (PCPlus4),
        .InstrValid    (InstrValid),
        .PC            (PC)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vector_t mkVec(
        input logic        stall,
        input logic        pcSrc,
        input logic [31:0] target,
        input logic        rdy,
        input logic        respValid,
        input logic [31:0] rData,
        input logic        expReq,
        input logic [31:0] expAddr,
        input logic [31:0] expInstr,
        input logic [31:0] expPcPlus4,
        input logic        expValid,
        input logic [31:0] expPc
    );
        vector_t v;
        v.stall      = stall;
        v.pcSrc      = pcSrc;
        v.target     = target;
        v.rdy        = rdy;
        v.respValid  = respValid;
        v.rData      = rData;
        v.expReq     = expReq;
        v.expAddr    = expAddr;
        v.expInstr   = expInstr;
        v.expPcPlus4 = expPcPlus4;
        v.expValid   = expValid;
        v.expPc      = expPc;
        return v;
    endfunction

    // Inputs are driven just after a rising edge so they are stable well
    // before the next one.
    task automatic applyStimulus(
        input logic        stall,
        input logic        pcSrc,
        input logic [31:0] target,
        input logic        rdy,
        input logic        respValid,
        input logic [31:0] rData
    );
        Stall         = stall;
        PCSrc         = pcSrc;
        BranchTarget  = target;
        IMemRdy       = rdy;
        IMemRespValid = respValid;
        IMemRData     = rData;
    endtask

    task automatic checkOutput(
        input string       name,
        input logic [31:0] actual,
        input logic [31:0] required
    );
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic checkAll(
        input string       tag,
        input logic        req,
        input logic [31:0] addr,
        input logic [31:0] instr,
        input logic [31:0] pcPlus4,
        input logic        valid,
        input logic [31:0] pc
    );
        checkOutput({tag, ".IMemReq"},     {31'd0, IMemReq},    {31'd0, req});
        checkOutput({tag, ".IMemAddr"},    IMemAddr,            addr);
        checkOutput({tag, ".Instruction"}, Instruction,         instr);
        checkOutput({tag, ".PCPlus4"},     PCPlus4,             pcPlus4);
        checkOutput({tag, ".InstrValid"},  {31'd0, InstrValid}, {31'd0, valid});
        checkOutput({tag, ".PC"},          PC,                  pc);
    endtask

    task automatic stepCycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //                stall pcSrc target        rdy  rv   rData           req  addr           instr          pc+4           vld  pc
        // basic fetch from address 0, then from 4 under stall into HOLD
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000));
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h8C01_0000,  1, 32'h0000_0004, 32'h8C01_0000, 32'h0000_0004, 1, 32'h0000_0004));
        vectors.push_back(mkVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0004, 32'h8C01_0000, 32'h0000_0004, 1, 32'h0000_0004));
        vectors.push_back(mkVec(1, 0, 32'h0,          0, 1, 32'hAC01_0000,  0, 32'h0000_0004, 32'h8C01_0000, 32'h0000_0004, 1, 32'h0000_0004));
        vectors.push_back(mkVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0004, 32'h8C01_0000, 32'h0000_0004, 1, 32'h0000_0004));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0008, 32'hAC01_0000, 32'h0000_0008, 1, 32'h0000_0008));
        // unaccepted request redirected to 0x100
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 0, 32'h0000_0008));
        vectors.push_back(mkVec(0, 1, 32'h0000_0100,  0, 0, 32'h0,          1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0008, 0, 32'h0000_0100));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0008, 0, 32'h0000_0100));
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0008, 0, 32'h0000_0100));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h0022_1820,  1, 32'h0000_0104, 32'h0022_1820, 32'h0000_0104, 1, 32'h0000_0104));
        // redirect in WAIT, wrong-path response arrives a cycle later
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0104, 0, 32'h0000_0104));
        vectors.push_back(mkVec(0, 1, 32'h0000_0043,  0, 0, 32'h0,          0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0104, 0, 32'h0000_0040));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0104, 0, 32'h0000_0040));
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0104, 0, 32'h0000_0040));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h2042_0001,  1, 32'h0000_0044, 32'h2042_0001, 32'h0000_0044, 1, 32'h0000_0044));
        // redirect out of HOLD under stall, to the top word of memory
        vectors.push_back(mkVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0044, 32'h2042_0001, 32'h0000_0044, 1, 32'h0000_0044));
        vectors.push_back(mkVec(1, 0, 32'h0,          0, 1, 32'h1111_1111,  0, 32'h0000_0044, 32'h2042_0001, 32'h0000_0044, 1, 32'h0000_0044));
        vectors.push_back(mkVec(1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0044, 0, 32'hFFFF_FFFC));
        // fetch at 0xFFFFFFFC wraps PC+4 to zero
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0044, 0, 32'hFFFF_FFFC));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h0800_0000,  1, 32'h0000_0000, 32'h0800_0000, 32'h0000_0000, 1, 32'h0000_0000));
        // redirect in the same cycle as the response
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000));
        vectors.push_back(mkVec(0, 1, 32'h0000_0200,  0, 1, 32'h3333_3333,  1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0200));
        // redirect in the same cycle the request is accepted
        vectors.push_back(mkVec(0, 1, 32'h0000_0300,  1, 0, 32'h0,          0, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0300));
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h4444_4444,  1, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0300));
        vectors.push_back(mkVec(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0300));
        // empty IF/ID loads even while stalled
        vectors.push_back(mkVec(1, 0, 32'h0,          0, 1, 32'h5555_5555,  1, 32'h0000_0304, 32'h5555_5555, 32'h0000_0304, 1, 32'h0000_0304));
        // stray response in REQ is ignored, decode drains to a bubble
        vectors.push_back(mkVec(0, 0, 32'h0,          0, 1, 32'h6666_6666,  1, 32'h0000_0304, 32'h0000_0000, 32'h0000_0304, 0, 32'h0000_0304));

        repeat (3) @(posedge Clk);
        #1;
        checkAll("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        Rst = 1'b1;
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].stall, vectors[i].pcSrc, vectors[i].target,
                          vectors[i].rdy, vectors[i].respValid, vectors[i].rData);
            stepCycle();
            checkAll($sformatf("vec%0d", i), vectors[i].expReq, vectors[i].expAddr,
                     vectors[i].expInstr, vectors[i].expPcPlus4, vectors[i].expValid,
                     vectors[i].expPc);
        end

        // Reset pulsed while a request is outstanding, then a late response.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepCycle();
        checkAll("rstPre", 1'b0, 32'h304, 32'h0, 32'h304, 1'b0, 32'h304);

        #2;
        Rst = 1'b0;
        #1;
        checkAll("rstAsync", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
        stepCycle();
        checkAll("rstHeld", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        Rst = 1'b1;
        stepCycle();
        checkAll("rstIdle", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        stepCycle();
        checkAll("rstStray", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepCycle();
        checkAll("rstAccept", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8C01_0000);
        stepCycle();
        checkAll("rstRefetch", 1'b1, 32'h4, 32'h8C01_0000, 32'h4, 1'b1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
